// File: rtl/taxel_scan_avg_if.sv
// Result stream between the taxel scan averager and the frame buffer/UART stage.
// Ports: res_valid/chan/data/err (master->slave), res_ready (slave->master).
interface taxel_scan_avg_if #(
  parameter int CH_W = 4
);
  logic            res_valid_out;
  logic            res_ready_in;
  logic [CH_W-1:0] res_chan_out;
  logic [11:0]     res_data_out;
  logic            res_err_out;

  modport master (
    output res_valid_out,
    output res_chan_out,
    output res_data_out,
    output res_err_out,
    input  res_ready_in
  );

  modport slave (
    input  res_valid_out,
    input  res_chan_out,
    input  res_data_out,
    input  res_err_out,
    output res_ready_in
  );
endinterface

// File: rtl/taxel_scan_avg.sv
// Taxel scan sequencer: steps the analog mux over NUM_CH channels, waits for
// settling, averages 2**AVG_LOG2 good reader samples per channel and streams
// one result per channel on res (valid/ready). Ports: clk, rst_n, start_in,
// sample_valid/error/data in, mux_sel/en, busy, frame_done, err_count, peak.
// Build option: define SCAN_PEAK_EN to track the per-frame peak result.
module taxel_scan_avg #(
  parameter int NUM_CH     = 16,
  parameter int CH_W       = 4,
  parameter int AVG_LOG2   = 2,
  parameter int SETTLE_CYC = 8,
  parameter int MAX_ERR    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic             sample_valid_in,
  input  logic             sample_error_in,
  input  logic [11:0]      sample_in,
  output logic [CH_W-1:0]  mux_sel_out,
  output logic             mux_en_out,
  output logic             busy_out,
  taxel_scan_avg_if.master res,
  output logic             frame_done_out,
  output logic [7:0]       err_count_out,
  output logic [11:0]      peak_val_out,
  output logic [CH_W-1:0]  peak_chan_out
);

  localparam int AW = 12 + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam int EW = $clog2(MAX_ERR + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  localparam logic [NW-1:0]   N_LAST = NW'((1 << AVG_LOG2) - 1);
  localparam logic [EW-1:0]   E_LAST = EW'(MAX_ERR - 1);
  localparam logic [SW-1:0]   S_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [CH_W-1:0] C_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_ACQ, S_OUT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] chan_q, chan_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [NW-1:0]   n_q, n_d;
  logic [EW-1:0]   errs_q, errs_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rv_q, rv_d;
  logic [CH_W-1:0] rch_q, rch_d;
  logic [11:0]     rdat_q, rdat_d;
  logic            rerr_q, rerr_d;

  logic [AW-1:0]   acc_sum;
  logic [11:0]     avg;

  assign acc_sum = acc_q + AW'(sample_in);
  assign avg     = 12'(acc_sum >> AVG_LOG2);

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    n_d       = n_q;
    errs_d    = errs_q;
    err_cnt_d = err_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rv_d      = rv_q;
    rch_d     = rch_q;
    rdat_d    = rdat_q;
    rerr_d    = rerr_q;

    // Every reader error counts, whatever the scan is doing.
    if (sample_valid_in && sample_error_in
        && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_SETTLE;
          chan_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == S_LAST) begin
          state_d = S_ACQ;
          acc_d   = '0;
          n_d     = '0;
          errs_d  = '0;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      S_ACQ: begin
        if (sample_valid_in) begin
          if (!sample_error_in) begin
            acc_d  = acc_sum;
            n_d    = n_q + NW'(1);
            errs_d = '0;
            if (n_q == N_LAST) begin
              state_d = S_OUT;
              rv_d    = 1'b1;
              rch_d   = chan_q;
              rdat_d  = avg;
              rerr_d  = 1'b0;
            end
          end else begin
            errs_d = errs_q + EW'(1);
            if (errs_q == E_LAST) begin
              state_d = S_OUT;
              rv_d    = 1'b1;
              rch_d   = chan_q;
              rdat_d  = 12'hFFF;
              rerr_d  = 1'b1;
            end
          end
        end
      end
      S_OUT: begin
        if (res.res_ready_in) begin
          rv_d = 1'b0;
          if (chan_q == C_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_SETTLE;
            chan_d  = chan_q + CH_W'(1);
            cnt_d   = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      chan_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      n_q       <= '0;
      errs_q    <= '0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rv_q      <= 1'b0;
      rch_q     <= '0;
      rdat_q    <= '0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      n_q       <= n_d;
      errs_q    <= errs_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rv_q      <= rv_d;
      rch_q     <= rch_d;
      rdat_q    <= rdat_d;
      rerr_q    <= rerr_d;
    end
  end

  assign mux_sel_out       = chan_q;
  assign mux_en_out        = busy_q;
  assign busy_out          = busy_q;
  assign frame_done_out    = done_q;
  assign err_count_out     = err_cnt_q;
  assign res.res_valid_out = rv_q;
  assign res.res_chan_out  = rch_q;
  assign res.res_data_out  = rdat_q;
  assign res.res_err_out   = rerr_q;

`ifdef SCAN_PEAK_EN
  logic            start_go, good_res, done_go;
  logic [11:0]     pk_run_q, pk_run_d;
  logic [CH_W-1:0] pk_rch_q, pk_rch_d;
  logic [11:0]     pk_val_q, pk_val_d;
  logic [CH_W-1:0] pk_ch_q, pk_ch_d;

  assign start_go = (state_q == S_IDLE) && start_in;
  assign good_res = (state_q == S_ACQ) && sample_valid_in
                    && !sample_error_in && (n_q == N_LAST);
  assign done_go  = (state_q == S_OUT) && res.res_ready_in
                    && (chan_q == C_LAST);

  always_comb begin
    pk_run_d = pk_run_q;
    pk_rch_d = pk_rch_q;
    pk_val_d = pk_val_q;
    pk_ch_d  = pk_ch_q;
    if (start_go) begin
      pk_run_d = '0;
      pk_rch_d = '0;
    end
    // Strict compare: channels ascend, so ties keep the lower one.
    if (good_res && avg > pk_run_q) begin
      pk_run_d = avg;
      pk_rch_d = chan_q;
    end
    if (done_go) begin
      pk_val_d = pk_run_q;
      pk_ch_d  = pk_rch_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_run_q <= '0;
      pk_rch_q <= '0;
      pk_val_q <= '0;
      pk_ch_q  <= '0;
    end else begin
      pk_run_q <= pk_run_d;
      pk_rch_q <= pk_rch_d;
      pk_val_q <= pk_val_d;
      pk_ch_q  <= pk_ch_d;
    end
  end

  assign peak_val_out  = pk_val_q;
  assign peak_chan_out = pk_ch_q;
`else
  assign peak_val_out  = '0;
  assign peak_chan_out = '0;
`endif

endmodule

// File: tb/tb_taxel_scan_avg.sv
// Scoreboard bench for taxel_scan_avg: random and directed frames, a
// behavioural per-channel averaging model, and a decoupled result monitor.
module tb_taxel_scan_avg;
  localparam int NUM_CH     = 16;
  localparam int CH_W       = 4;
  localparam int AVG_LOG2   = 2;
  localparam int SETTLE_CYC = 8;
  localparam int MAX_ERR    = 3;
  localparam int NS         = 1 << AVG_LOG2;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [11:0]     data;
    logic            err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_in = 1'b0;
  logic            sv = 1'b0;
  logic            se = 1'b0;
  logic [11:0]     sd = '0;
  logic [CH_W-1:0] mux_sel_out;
  logic            mux_en_out;
  logic            busy_out;
  logic            frame_done_out;
  logic [7:0]      err_count_out;
  logic [11:0]     peak_val_out;
  logic [CH_W-1:0] peak_chan_out;

  taxel_scan_avg_if #(.CH_W(CH_W)) rif ();

  taxel_scan_avg #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .AVG_LOG2(AVG_LOG2),
    .SETTLE_CYC(SETTLE_CYC), .MAX_ERR(MAX_ERR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_in(start_in),
    .sample_valid_in(sv),
    .sample_error_in(se),
    .sample_in(sd),
    .mux_sel_out(mux_sel_out),
    .mux_en_out(mux_en_out),
    .busy_out(busy_out),
    .res(rif),
    .frame_done_out(frame_done_out),
    .err_count_out(err_count_out),
    .peak_val_out(peak_val_out),
    .peak_chan_out(peak_chan_out)
  );

  always #10 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];
  int   model_errs = 0;
  int   pk_v;
  int   pk_c;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic e,
                       input logic [11:0] d);
    sv = v; se = e; sd = d;
    tick();
    sv = 1'b0; se = 1'b0; sd = '0;
  endtask

  // Samples the DUT must ignore, with a stray start pulse mixed in.
  task automatic junk(input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      e = ($urandom_range(0, 3) == 0);
      if (e) model_errs++;
      start_in = (i == 1);
      drive(1'b1, e, 12'($urandom));
      start_in = 1'b0;
    end
  endtask

  // Reference: average of NS good samples, or give-up after
  // MAX_ERR errors in a row. Returns 1 once the plan completes.
  function automatic bit model(input logic [12:0] p[$],
                               input int k,
                               output exp_t r);
    int sum = 0;
    int n = 0;
    int run = 0;
    r = '{ch: CH_W'(k), data: 12'd0, err: 1'b0};
    foreach (p[i]) begin
      if (p[i][12]) begin
        run++;
        if (run == MAX_ERR) begin
          r.data = 12'hFFF;
          r.err  = 1'b1;
          return 1'b1;
        end
      end else begin
        sum += int'(p[i][11:0]);
        n++;
        run = 0;
        if (n == NS) begin
          r.data = 12'(sum / NS);
          return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic run_channel(input int mode, input int k);
    logic [12:0] p[$];
    exp_t        e;
    bit          done;
    int          stall;
    junk(3);
    repeat (SETTLE_CYC - 2) tick();
    chk("mux_sel", 32'(mux_sel_out), 32'(k));
    chk("busy", 32'(busy_out), 32'd1);
    p = {};
    stall = $urandom_range(0, 12);
    if (mode == 1) begin
      repeat (NS) p.push_back({1'b0, 12'(k * 16)});
    end else if (mode == 2 && k == 2) begin
      repeat (MAX_ERR) p.push_back(13'h1000);
    end else if (mode == 2 && k == 3) begin
      p = '{13'd1, 13'd2, 13'd2, 13'd2};
    end else if (mode == 2 && k == 4) begin
      repeat (NS) p.push_back(13'h0FFF);
    end else if (mode == 2 && k == 5) begin
      for (int i = 1; i <= NS; i++) begin
        p.push_back(13'h1000);
        p.push_back(13'(i * 100));
      end
    end
    if (mode == 2 && k == 6) stall = 20;
    done = model(p, k, e);
    while (!done) begin
      p.push_back({($urandom_range(0, 3) == 0), 12'($urandom)});
      done = model(p, k, e);
    end
    sb.push_back(e);
    if (!e.err && int'(e.data) > pk_v) begin
      pk_v = int'(e.data);
      pk_c = k;
    end
    foreach (p[i]) if (p[i][12]) model_errs++;
    foreach (p[i]) begin
      drive(1'b1, p[i][12], p[i][11:0]);
      repeat ($urandom_range(0, 2)) tick();
    end
    junk(2);
    for (int w = 0; w < 20 && !rif.res_valid_out; w++) tick();
    chk("res_valid_wait", 32'(rif.res_valid_out), 32'd1);
    repeat (stall) tick();
    chk("no_advance", 32'(mux_sel_out), 32'(k));
    rif.res_ready_in = 1'b1;
    tick();
    rif.res_ready_in = 1'b0;
  endtask

  task automatic run_frame(input int mode);
    int ev;
    int ec;
    pk_v = 0;
    pk_c = 0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int k = 0; k < NUM_CH; k++) run_channel(mode, k);
    chk("frame_done", 32'(frame_done_out), 32'd1);
    chk("busy_done", 32'(busy_out), 32'd0);
    chk("mux_en_done", 32'(mux_en_out), 32'd0);
`ifdef SCAN_PEAK_EN
    ev = pk_v;
    ec = pk_c;
`else
    ev = 0;
    ec = 0;
`endif
    chk("peak_val", 32'(peak_val_out), 32'(ev));
    chk("peak_chan", 32'(peak_chan_out), 32'(ec));
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk("frame_done_pulse", 32'(frame_done_out), 32'd0);
    tick();
    chk("start_in_done_ignored", 32'(busy_out), 32'd0);
    chk("err_count", 32'(err_count_out),
        32'(model_errs > 255 ? 255 : model_errs));
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_mux_en", 32'(mux_en_out), 32'd0);
    chk("rst_mux_sel", 32'(mux_sel_out), 32'd0);
    chk("rst_res_valid", 32'(rif.res_valid_out), 32'd0);
    chk("rst_res_chan", 32'(rif.res_chan_out), 32'd0);
    chk("rst_res_data", 32'(rif.res_data_out), 32'd0);
    chk("rst_res_err", 32'(rif.res_err_out), 32'd0);
    chk("rst_frame_done", 32'(frame_done_out), 32'd0);
    chk("rst_err_count", 32'(err_count_out), 32'd0);
    chk("rst_peak_val", 32'(peak_val_out), 32'd0);
    chk("rst_peak_chan", 32'(peak_chan_out), 32'd0);
  endtask

  // Monitor: checks hold under backpressure and pops on handshake.
  initial begin : monitor
    logic            pv;
    logic [CH_W-1:0] pc;
    logic [11:0]     pd;
    logic            pe;
    exp_t            x;
    pv = 1'b0; pc = '0; pd = '0; pe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv)
          chk("res_hold",
              32'({rif.res_valid_out, rif.res_chan_out,
                   rif.res_data_out, rif.res_err_out}),
              32'({1'b1, pc, pd, pe}));
        if (rif.res_valid_out && rif.res_ready_in) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL extra_result: got ch %0d, none expected",
                     rif.res_chan_out);
          end else begin
            x = sb.pop_front();
            chk("res_chan", 32'(rif.res_chan_out), 32'(x.ch));
            chk("res_data", 32'(rif.res_data_out), 32'(x.data));
            chk("res_err", 32'(rif.res_err_out), 32'(x.err));
          end
          pv = 1'b0;
        end else begin
          pv = rif.res_valid_out;
          pc = rif.res_chan_out;
          pd = rif.res_data_out;
          pe = rif.res_err_out;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    rif.res_ready_in = 1'b0;
    repeat (3) tick();
    chk_reset_outputs();
    rst_n = 1'b1;
    tick();
    run_frame(1);
    run_frame(2);
    run_frame(0);
    // Abort mid-acquisition on channel 0.
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (SETTLE_CYC + 1) tick();
    drive(1'b1, 1'b1, 12'h123);
    drive(1'b1, 1'b0, 12'h456);
    drive(1'b1, 1'b0, 12'h789);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_errs = 0;
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(0);
    run_frame(0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
